pc_fetch_controller: RTL

- Consumer end of the EX-stage redirect interface: samples `flush` and `pc_update_mux_signal` (00 seq, 01 PC+imm, 10 JLR register, 11 JRI) every cycle.
- Owns the architectural PC register, sequences instruction-memory fetch with a ready handshake, and honours load-use stalls.
- On a redirect it loads the selected target and issues one-cycle kill pulses to the IF/ID, ID/RR and RR/EX pipeline registers.
- Sits at the front of the IF stage, feeding imem and the IF/ID register.

---
 rtl/pc_fetch_controller.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_controller.sv
// Front-of-IF program counter owner: sequences imem fetches, honours load-use stalls,
// and takes EX-stage redirects with one-cycle squash pulses to the upstream pipeline registers.
module pc_fetch_controller #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [1:0]  pc_update_mux_signal,
    input  logic [15:0] branch_target,
    input  logic [15:0] jlr_target,
    input  logic [15:0] jri_target,
    input  logic        stall,
    input  logic        imem_ready,
    output logic [15:0] pc_out,
    output logic        imem_req,
    output logic        if_valid,
    output logic        kill_if_id,
    output logic        kill_id_rr,
    output logic        kill_rr_ex,
    output logic [7:0]  redirect_count,
    output logic        protocol_err
);

    // Handshake: a fetch completes on an edge where imem_req=1, imem_ready=1 and stall=0;
    // if_valid is high in the cycle after that edge. A redirect preempts any pending fetch.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        FETCH    = 2'b01,
        WAIT_MEM = 2'b10,
        REDIRECT = 2'b11
    } state_t;

    state_t      state, state_next;
    logic [15:0] pc_next;
    logic [15:0] target;
    logic        if_valid_next;
    logic        sel_nz;
    logic        redirect_req;
    logic        malformed;
    logic        take_redirect;

    always_comb begin
        sel_nz       = (pc_update_mux_signal != 2'b00);
        redirect_req = flush && sel_nz;
        malformed    = flush != sel_nz;
        target       = branch_target;
        unique case (pc_update_mux_signal)
            2'b10:   target = jlr_target;
            2'b11:   target = jri_target;
            default: target = branch_target;
        endcase
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc_out;
        if_valid_next = 1'b0;
        take_redirect = 1'b0;
        unique case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (redirect_req) begin
                    take_redirect = 1'b1;
                end else if (stall) begin
                    state_next = FETCH;
                end else if (!imem_ready) begin
                    state_next = WAIT_MEM;
                end else begin
                    pc_next       = pc_out + PC_INC;
                    if_valid_next = 1'b1;
                end
            end
            WAIT_MEM: begin
                if (redirect_req) begin
                    take_redirect = 1'b1;
                end else if (imem_ready && !stall) begin
                    pc_next       = pc_out + PC_INC;
                    if_valid_next = 1'b1;
                    state_next    = FETCH;
                end
            end
            REDIRECT: begin
                if (redirect_req) take_redirect = 1'b1;
                else              state_next    = FETCH;
            end
            default: state_next = IDLE;
        endcase
        // Redirect from IDLE is ignored: the pipeline behind us holds nothing yet.
        if (take_redirect) begin
            pc_next    = {target[15:1], 1'b0};
            state_next = REDIRECT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc_out         <= RESET_PC;
            imem_req       <= 1'b0;
            if_valid       <= 1'b0;
            kill_if_id     <= 1'b0;
            kill_id_rr     <= 1'b0;
            kill_rr_ex     <= 1'b0;
            redirect_count <= 8'h00;
            protocol_err   <= 1'b0;
        end else begin
            state          <= state_next;
            pc_out         <= pc_next;
            imem_req       <= (state_next == FETCH) || (state_next == WAIT_MEM);
            if_valid       <= if_valid_next;
            kill_if_id     <= (state_next == REDIRECT);
            kill_id_rr     <= (state_next == REDIRECT);
            kill_rr_ex     <= (state_next == REDIRECT);
            if (take_redirect && (redirect_count != 8'hFF))
                redirect_count <= redirect_count + 8'd1;
            if (malformed || (take_redirect && target[0]))
                protocol_err <= 1'b1;
        end
    end

endmodule
